// File: rtl/int_ctrl_pkg.sv
// Shared definitions for the memory-mapped interrupt controller:
// register word offsets, CTRL bit positions and the CTRL register layout.
package int_ctrl_pkg;

    // Word indices, compared against bus_addr[7:2]
    localparam logic [5:0] INTC_PEND = 6'h00;
    localparam logic [5:0] INTC_MASK = 6'h01;
    localparam logic [5:0] INTC_VEC  = 6'h02;
    localparam logic [5:0] INTC_TCMP = 6'h03;
    localparam logic [5:0] INTC_TCNT = 6'h04;
    localparam logic [5:0] INTC_CTRL = 6'h05;

    localparam int unsigned CTRL_GEN = 0;
    localparam int unsigned CTRL_TEN = 1;
    localparam int unsigned CTRL_TAR = 2;

    typedef struct packed {
        logic tar;
        logic ten;
        logic gen;
    } ctrl_t;

    function automatic logic [31:0] ctrl_to_word(input ctrl_t c);
        logic [31:0] w;
        w           = '0;
        w[CTRL_GEN] = c.gen;
        w[CTRL_TEN] = c.ten;
        w[CTRL_TAR] = c.tar;
        return w;
    endfunction

    function automatic ctrl_t word_to_ctrl(input logic [31:0] w);
        ctrl_t c;
        c.gen = w[CTRL_GEN];
        c.ten = w[CTRL_TEN];
        c.tar = w[CTRL_TAR];
        return c;
    endfunction

endpackage

// File: rtl/int_ctrl_sync_edge.sv
// Multi-bit input synchroniser followed by a rising-edge detector; o_rise is a
// one-cycle pulse per 0->1 transition seen at the synchroniser output.
module intc_sync_edge #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 2
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic [WIDTH-1:0] i_d,
    output logic [WIDTH-1:0] o_rise
);

    logic [DEPTH-1:0][WIDTH-1:0] r_sync;
    logic [WIDTH-1:0]            r_prev;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_sync <= '0;
            r_prev <= '0;
        end else begin
            r_sync[0] <= i_d;
            for (int unsigned i = 1; i < DEPTH; i++) begin
                r_sync[i] <= r_sync[i-1];
            end
            r_prev <= r_sync[DEPTH-1];
        end
    end

    assign o_rise = r_sync[DEPTH-1] & ~r_prev;

endmodule

// File: rtl/int_ctrl.sv
// Memory-mapped interrupt controller: edge-latched external sources plus a
// compare timer (highest priority), with mask, global enable and vector readout.
module int_ctrl #(
    parameter int unsigned N_SRC       = 8,
    parameter logic [31:0] BASE_ADDR   = 32'hFFFF_FF00,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic [N_SRC-1:0] i_irq_src,
    input  logic             i_bus_ren,
    input  logic             i_bus_wen,
    input  logic [31:0]      i_bus_addr,
    input  logic [31:0]      i_bus_wdata,
    output logic [31:0]      o_bus_rdata,
    output logic             o_bus_hit,
    output logic             o_ir_in,
    output logic             o_int_cause
);

    import int_ctrl_pkg::*;

    localparam int unsigned NP = N_SRC + 1;

    logic [NP-1:0]    r_pend;
    logic [NP-1:0]    r_mask;
    logic [31:0]      r_tcmp;
    logic [31:0]      r_tcnt;
    ctrl_t            r_ctrl;
    logic             r_ir;
    logic             r_cause;

    logic [N_SRC-1:0] w_rise;
    logic             w_hit;
    logic [5:0]       w_off;
    logic             w_wr;
    logic             w_wr_pend;
    logic             w_wr_mask;
    logic             w_wr_tcmp;
    logic             w_wr_tcnt;
    logic             w_wr_ctrl;
    logic             w_match;
    logic [31:0]      w_tcnt_d;
    ctrl_t            w_ctrl_d;
    logic [NP-1:0]    w_pend_d;
    logic [NP-1:0]    w_enpend;
    logic             w_any;
    logic [4:0]       w_vec_idx;
    logic [31:0]      w_rdata;
    logic             w_unused;

    intc_sync_edge #(
        .WIDTH (N_SRC),
        .DEPTH (SYNC_STAGES)
    ) u_sync_edge (
        .i_clk  (i_clk),
        .i_rst  (i_rst),
        .i_d    (i_irq_src),
        .o_rise (w_rise)
    );

    assign w_hit     = (i_bus_addr[31:8] == BASE_ADDR[31:8]);
    assign w_off     = i_bus_addr[7:2];
    assign w_wr      = i_bus_wen & w_hit;
    assign w_wr_pend = w_wr && (w_off == INTC_PEND);
    assign w_wr_mask = w_wr && (w_off == INTC_MASK);
    assign w_wr_tcmp = w_wr && (w_off == INTC_TCMP);
    assign w_wr_tcnt = w_wr && (w_off == INTC_TCNT);
    assign w_wr_ctrl = w_wr && (w_off == INTC_CTRL);
    assign w_unused  = ^i_bus_addr[1:0];

    assign w_match = r_ctrl.ten && (r_tcnt == r_tcmp);

    // CPU writes to TCNT/CTRL take precedence over the timer's own update
    always_comb begin
        w_tcnt_d = r_tcnt;
        w_ctrl_d = r_ctrl;
        if (r_ctrl.ten) begin
            if (w_match) begin
                if (r_ctrl.tar) begin
                    w_tcnt_d = '0;
                end else begin
                    w_ctrl_d.ten = 1'b0;
                end
            end else begin
                w_tcnt_d = r_tcnt + 32'd1;
            end
        end
        if (w_wr_tcnt) begin
            w_tcnt_d = i_bus_wdata;
        end
        if (w_wr_ctrl) begin
            w_ctrl_d = word_to_ctrl(i_bus_wdata);
        end
    end

    // New events win over a same-cycle W1C of the same bit
    always_comb begin
        w_pend_d = r_pend;
        if (w_wr_pend) begin
            w_pend_d = r_pend & ~i_bus_wdata[NP-1:0];
        end
        w_pend_d = w_pend_d | {w_match, w_rise};
    end

    assign w_enpend = r_pend & r_mask;
    assign w_any    = |w_enpend;

    always_comb begin
        w_vec_idx = '0;
        for (int i = int'(N_SRC) - 1; i >= 0; i--) begin
            if (w_enpend[i]) begin
                w_vec_idx = 5'(i);
            end
        end
        if (w_enpend[N_SRC]) begin
            w_vec_idx = 5'(N_SRC);
        end
    end

    always_comb begin
        w_rdata = '0;
        if (i_bus_ren && w_hit) begin
            case (w_off)
                INTC_PEND: w_rdata = 32'(r_pend);
                INTC_MASK: w_rdata = 32'(r_mask);
                INTC_VEC:  w_rdata = w_any ? {1'b1, 26'd0, w_vec_idx} : 32'd0;
                INTC_TCMP: w_rdata = r_tcmp;
                INTC_TCNT: w_rdata = r_tcnt;
                INTC_CTRL: w_rdata = ctrl_to_word(r_ctrl);
                default:   w_rdata = '0;
            endcase
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_pend  <= '0;
            r_mask  <= '0;
            r_tcmp  <= '0;
            r_tcnt  <= '0;
            r_ctrl  <= '0;
            r_ir    <= 1'b0;
            r_cause <= 1'b0;
        end else begin
            r_pend <= w_pend_d;
            r_tcnt <= w_tcnt_d;
            r_ctrl <= w_ctrl_d;
            if (w_wr_mask) begin
                r_mask <= i_bus_wdata[NP-1:0];
            end
            if (w_wr_tcmp) begin
                r_tcmp <= i_bus_wdata;
            end
            r_ir    <= r_ctrl.gen & (|(r_pend & r_mask));
            r_cause <= r_ctrl.gen & r_pend[N_SRC] & r_mask[N_SRC];
        end
    end

    assign o_bus_rdata = w_rdata;
    assign o_bus_hit   = w_hit;
    assign o_ir_in     = r_ir;
    assign o_int_cause = r_cause;

endmodule

// File: tb/tb_int_ctrl.sv
// Directed scoreboard bench for int_ctrl: expectations are queued as stimulus
// is applied and popped when the corresponding DUT output is sampled.
module tb_int_ctrl;

    localparam int unsigned N_SRC   = 8;
    localparam logic [23:0] BASE_HI = 24'hFF_FFFF;
    localparam logic [7:0]  PEND    = 8'h00;
    localparam logic [7:0]  MASK    = 8'h04;
    localparam logic [7:0]  VEC     = 8'h08;
    localparam logic [7:0]  TCMP    = 8'h0C;
    localparam logic [7:0]  TCNT    = 8'h10;
    localparam logic [7:0]  CTRL    = 8'h14;

    logic             clk = 1'b0;
    logic             rst;
    logic [N_SRC-1:0] irq;
    logic             ren;
    logic             wen;
    logic [31:0]      addr;
    logic [31:0]      wdata;
    logic [31:0]      rdata;
    logic             hit;
    logic             ir_in;
    logic             int_cause;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        string       tag;
        logic [31:0] exp;
    } sb_item_t;

    sb_item_t sb[$];

    always #5 clk = ~clk;

    int_ctrl #(
        .N_SRC       (N_SRC),
        .BASE_ADDR   (32'hFFFF_FF00),
        .SYNC_STAGES (2)
    ) dut (
        .i_clk       (clk),
        .i_rst       (rst),
        .i_irq_src   (irq),
        .i_bus_ren   (ren),
        .i_bus_wen   (wen),
        .i_bus_addr  (addr),
        .i_bus_wdata (wdata),
        .o_bus_rdata (rdata),
        .o_bus_hit   (hit),
        .o_ir_in     (ir_in),
        .o_int_cause (int_cause)
    );

    task automatic push(input string tag, input logic [31:0] exp);
        sb_item_t it;
        it.tag = tag;
        it.exp = exp;
        sb.push_back(it);
    endtask

    task automatic pop_cmp(input logic [31:0] obs);
        sb_item_t it;
        n_tests++;
        if (sb.size() == 0) begin
            n_fail++;
            $display("FAIL scoreboard: observed 0x%08h with nothing queued", obs);
            return;
        end
        it = sb.pop_front();
        assert (obs === it.exp) else begin
            n_fail++;
            $display("FAIL %s: observed 0x%08h expected 0x%08h", it.tag, obs, it.exp);
            $error("check %s", it.tag);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [7:0] off, input logic [31:0] d);
        wen   = 1'b1;
        addr  = {BASE_HI, off};
        wdata = d;
        @(posedge clk);
        #1;
        wen   = 1'b0;
        addr  = '0;
        wdata = '0;
    endtask

    task automatic rd(input string tag, input logic [7:0] off, input logic [31:0] exp);
        push(tag, exp);
        ren  = 1'b1;
        addr = {BASE_HI, off};
        #1;
        pop_cmp(rdata);
        ren  = 1'b0;
        addr = '0;
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        push(tag, {31'd0, exp});
        pop_cmp({31'd0, obs});
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: observed timeout expected $finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; irq = '0; ren = 1'b0; wen = 1'b0; addr = '0; wdata = '0;
        cyc(3);
        chk1("rst_ir_in", ir_in, 1'b0);
        chk1("rst_int_cause", int_cause, 1'b0);
        rst = 1'b0;
        rd("rst_pend", PEND, 32'h0);
        rd("rst_mask", MASK, 32'h0);
        rd("rst_tcnt", TCNT, 32'h0);
        rd("rst_ctrl", CTRL, 32'h0);
        rd("rst_vec", VEC, 32'h0);
        // Hit but no read strobe
        addr = {BASE_HI, MASK};
        #1;
        chk1("idle_hit", hit, 1'b1);
        push("idle_rdata", 32'h0);
        pop_cmp(rdata);
        addr = '0;

        // Single source, held high
        wr(MASK, 32'h1FF);
        wr(CTRL, 32'h1);
        rd("mask_rb", MASK, 32'h1FF);
        irq[3] = 1'b1;
        cyc(2);
        rd("t1_pend_early", PEND, 32'h0);
        cyc(1);
        rd("t1_pend", PEND, 32'h008);
        chk1("t1_ir_lag", ir_in, 1'b0);
        cyc(1);
        chk1("t1_ir_in", ir_in, 1'b1);
        chk1("t1_cause", int_cause, 1'b0);
        rd("t1_vec", VEC, 32'h8000_0003);
        wr(PEND, 32'h008);
        rd("t1_w1c", PEND, 32'h0);
        cyc(1);
        chk1("t1_ir_drop", ir_in, 1'b0);
        cyc(4);
        rd("t1_no_retrig", PEND, 32'h0);
        irq = '0;
        cyc(3);

        // Two sources together: lowest index wins
        irq = 8'h24;
        cyc(3);
        rd("t2_pend", PEND, 32'h024);
        rd("t2_vec", VEC, 32'h8000_0002);
        wr(PEND, 32'h004);
        rd("t2_vec_next", VEC, 32'h8000_0005);
        wr(PEND, 32'h020);
        irq = '0;
        cyc(3);

        // Edge lands in the same cycle as a W1C of that bit
        irq[1] = 1'b1;
        cyc(2);
        wr(PEND, 32'h002);
        rd("t4_set_beats_clr", PEND, 32'h002);
        wr(PEND, 32'h002);
        rd("t4_cleared", PEND, 32'h0);
        irq = '0;
        cyc(3);

        // Mask, global enable and address decode
        wr(MASK, 32'h0);
        irq = 8'hFF;
        cyc(4);
        rd("t5_pend", PEND, 32'h0FF);
        chk1("t5_masked_ir", ir_in, 1'b0);
        wr(MASK, 32'h001);
        chk1("t5_ir_lag", ir_in, 1'b0);
        cyc(1);
        chk1("t5_unmask_ir", ir_in, 1'b1);
        wr(CTRL, 32'h0);
        cyc(1);
        chk1("t5_gen_off_ir", ir_in, 1'b0);
        rd("t5_pend_kept", PEND, 32'h0FF);
        rd("t5_unmapped", 8'h18, 32'h0);
        ren  = 1'b1;
        addr = 32'h0000_0004;
        #1;
        chk1("t5_out_hit", hit, 1'b0);
        push("t5_out_rdata", 32'h0);
        pop_cmp(rdata);
        ren  = 1'b0;
        wen  = 1'b1;
        wdata = 32'h0;
        cyc(1);
        wen  = 1'b0;
        addr = '0;
        rd("t5_out_wr_ignored", MASK, 32'h001);
        wr(PEND, 32'h1FF);
        irq = '0;
        wr(CTRL, 32'h1);
        cyc(3);
        rd("t5_clean", PEND, 32'h0);

        // Timer with auto-reload
        wr(MASK, 32'h100);
        wr(TCMP, 32'd10);
        wr(TCNT, 32'd0);
        wr(CTRL, 32'h7);
        cyc(10);
        rd("t3_tcnt_at_cmp", TCNT, 32'd10);
        rd("t3_pend_early", PEND, 32'h0);
        cyc(1);
        rd("t3_pend", PEND, 32'h100);
        rd("t3_reload", TCNT, 32'd0);
        cyc(1);
        chk1("t3_ir_in", ir_in, 1'b1);
        chk1("t3_cause", int_cause, 1'b1);
        rd("t3_counting", TCNT, 32'd1);
        rd("t3_vec", VEC, 32'h8000_0008);

        // Timer one-shot
        wr(CTRL, 32'h1);
        wr(PEND, 32'h100);
        wr(TCNT, 32'd0);
        wr(CTRL, 32'h3);
        cyc(10);
        rd("t3b_tcnt", TCNT, 32'd10);
        cyc(1);
        rd("t3b_pend", PEND, 32'h100);
        rd("t3b_hold", TCNT, 32'd10);
        rd("t3b_ctrl", CTRL, 32'h1);
        cyc(3);
        rd("t3b_still_held", TCNT, 32'd10);

        // Counter wrap is not an event
        wr(PEND, 32'h100);
        wr(TCMP, 32'd5);
        wr(TCNT, 32'hFFFF_FFFE);
        wr(CTRL, 32'h3);
        cyc(1);
        rd("wrap_max", TCNT, 32'hFFFF_FFFF);
        cyc(1);
        rd("wrap_zero", TCNT, 32'h0);
        rd("wrap_no_event", PEND, 32'h0);
        wr(CTRL, 32'h1);

        // Reset with timer running and all pending
        wr(MASK, 32'h1FF);
        wr(TCMP, 32'd3);
        wr(TCNT, 32'd0);
        wr(CTRL, 32'h7);
        irq = 8'hFF;
        cyc(4);
        rd("t6_pend_all", PEND, 32'h1FF);
        rst = 1'b1;
        irq = '0;
        cyc(1);
        chk1("t6_ir_after_rst", ir_in, 1'b0);
        chk1("t6_cause_after_rst", int_cause, 1'b0);
        cyc(1);
        rst = 1'b0;
        rd("t6_pend", PEND, 32'h0);
        rd("t6_mask", MASK, 32'h0);
        rd("t6_tcmp", TCMP, 32'h0);
        rd("t6_tcnt", TCNT, 32'h0);
        rd("t6_ctrl", CTRL, 32'h0);
        rd("t6_vec", VEC, 32'h0);
        cyc(3);
        rd("t6_tcnt_stopped", TCNT, 32'h0);
        rd("t6_no_late_edge", PEND, 32'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
